// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-flop line sync, mid-bit sampling, false-start rejection, stop/frame check.
// Optional parity bit after the data field when UART_RX_PARITY_EN is defined (default build: no parity).
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy,
  output logic [2:0]           o_dbg_state
);

  localparam int BAUD_END = CLK_FREQ / BAUD - 1;
  localparam int BAUD_MID = BAUD_END / 2;
  localparam int CW       = $clog2(BAUD_END + 1);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_END_C = CW'(BAUD_END);
  localparam logic [CW-1:0] BAUD_MID_C = CW'(BAUD_MID);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic                 r_rx1;
  logic                 r_rx2;
  logic                 r_rx3;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_po_flag;
  logic                 r_frame_err;

  logic w_fall;
  logic w_mid;
  logic w_par_bad;

  assign w_fall = ~r_rx2 & r_rx3;
  assign w_mid  = (r_baud_cnt == BAUD_MID_C);

  // Line synchroniser; r_rx2 is the only sampled copy of the line, r_rx3 only feeds edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx1 <= 1'b1;
      r_rx2 <= 1'b1;
      r_rx3 <= 1'b1;
    end else begin
      r_rx1 <= rs232_rx;
      r_rx2 <= r_rx1;
      r_rx3 <= r_rx2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
    end else if (r_state == ST_IDLE || r_baud_cnt == BAUD_END_C) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;

  assign w_par_bad  = r_par ^ (^r_shift) ^ PAR_ODD;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_po_flag    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_po_flag    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_fall) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          // A start bit that is high again at mid-bit was a glitch: drop it silently.
          if (w_mid) begin
            r_state <= r_rx2 ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_mid) begin
            r_shift <= {r_rx2, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_mid) begin
            r_par   <= r_rx2;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (w_mid) begin
            if (r_rx2) begin
              r_state <= ST_IDLE;
              if (!w_par_bad) begin
                r_rx_data <= r_shift;
                r_po_flag <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              r_parity_err <= w_par_bad;
`endif
            end else begin
              r_state     <= ST_BREAK;
              r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= w_par_bad;
`endif
            end
          end
        end
        ST_BREAK: begin
          // Line held low after a bad stop bit: wait for idle, no new frame meanwhile.
          if (r_rx2) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign po_flag     = r_po_flag;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8-bit and 7-bit receivers at 10 clk/bit, directed and random frames.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLK  = 10;
  localparam logic ODD8   = 1'b1;
  localparam logic ODD7   = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic line8 = 1'b1;
  logic line7 = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data8;
  logic       po8, fe8, pe8, busy8;
  logic [2:0] dbg8;
  logic [6:0] rx_data7;
  logic       po7, fe7, pe7, busy7;
  logic [2:0] dbg7;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY_ODD(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line8), .rx_data(rx_data8), .po_flag(po8),
    .frame_err(fe8), .parity_err(pe8), .busy(busy8), .o_dbg_state(dbg8)
  );

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY_ODD(0)) dut7 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line7), .rx_data(rx_data7), .po_flag(po7),
    .frame_err(fe7), .parity_err(pe7), .busy(busy7), .o_dbg_state(dbg7)
  );

  int tests_run = 0;
  int fails     = 0;

  // scoreboard state
  logic [7:0] exp_q8[$];
  logic [6:0] exp_q7[$];
  logic [7:0] last8 = '0;
  logic [6:0] last7 = '0;
  int e_po8 = 0, e_fe8 = 0, e_pe8 = 0, n_po8 = 0, n_fe8 = 0, n_pe8 = 0;
  int e_po7 = 0, e_fe7 = 0, e_pe7 = 0, n_po7 = 0, n_fe7 = 0, n_pe7 = 0;
  logic prev_po8 = 1'b0, prev_po7 = 1'b0, saw_busy8 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobe monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy8) saw_busy8 = 1'b1;
      if (po8) begin
        n_po8++;
        check("po8_one_cycle", {31'b0, prev_po8}, 32'd0);
        tests_run++;
        assert (exp_q8.size() != 0) else begin
          fails++;
          $error("FAIL po8_unexpected: got strobe with data %0h expected none", rx_data8);
        end
        if (exp_q8.size() != 0) check("rx_data8_strobe", {24'b0, rx_data8}, {24'b0, exp_q8.pop_front()});
      end
      if (po7) begin
        n_po7++;
        check("po7_one_cycle", {31'b0, prev_po7}, 32'd0);
        tests_run++;
        assert (exp_q7.size() != 0) else begin
          fails++;
          $error("FAIL po7_unexpected: got strobe with data %0h expected none", rx_data7);
        end
        if (exp_q7.size() != 0) check("rx_data7_strobe", {25'b0, rx_data7}, {25'b0, exp_q7.pop_front()});
      end
      if (fe8) n_fe8++;
      if (pe8) n_pe8++;
      if (fe7) n_fe7++;
      if (pe7) n_pe7++;
    end
    prev_po8 = po8;
    prev_po7 = po7;
  end

  // driver: start, data LSB first, optional parity, stop; bit lengths alternate pa/pb
  task automatic drive_frame(input int sel, input logic [7:0] d, input int nb, input logic stop_val,
                             input logic par_flip, input int pa, input int pb);
    logic b_q[$];
    logic p;
    b_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) b_q.push_back(d[i]);
    if (PAR_EN) begin
      p = par_flip ^ ((sel == 0) ? ODD8 : ODD7);
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      b_q.push_back(p);
    end
    b_q.push_back(stop_val);
    foreach (b_q[i]) begin
      if (sel == 0) line8 = b_q[i];
      else line7 = b_q[i];
      repeat ((i % 2 == 0) ? pa : pb) @(negedge clk);
    end
  endtask

  // reference model: good frame -> data, bad stop -> frame error (+parity if bad), bad parity -> parity error
  task automatic frame8(input logic [7:0] d, input logic stop_val, input logic par_flip, input int pa, input int pb);
    logic par_bad;
    par_bad = PAR_EN && par_flip;
    if (!stop_val) begin
      e_fe8++;
      if (par_bad) e_pe8++;
    end else if (par_bad) begin
      e_pe8++;
    end else begin
      exp_q8.push_back(d);
      last8 = d;
      e_po8++;
    end
    drive_frame(0, d, 8, stop_val, par_flip, pa, pb);
  endtask

  task automatic frame7(input logic [6:0] d, input logic par_flip);
    logic par_bad;
    par_bad = PAR_EN && par_flip;
    if (par_bad) begin
      e_pe7++;
    end else begin
      exp_q7.push_back(d);
      last7 = d;
      e_po7++;
    end
    drive_frame(1, {1'b0, d}, 7, 1'b1, par_flip, BIT_CLK, BIT_CLK);
  endtask

  task automatic check8(input string tag);
    check({tag, "_po8_count"}, n_po8, e_po8);
    check({tag, "_fe8_count"}, n_fe8, e_fe8);
    check({tag, "_pe8_count"}, n_pe8, e_pe8);
    check({tag, "_rx_data8"}, {24'b0, rx_data8}, {24'b0, last8});
  endtask

  task automatic check7(input string tag);
    check({tag, "_po7_count"}, n_po7, e_po7);
    check({tag, "_pe7_count"}, n_pe7, e_pe7);
    check({tag, "_rx_data7"}, {25'b0, rx_data7}, {25'b0, last7});
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_rx_data8", {24'b0, rx_data8}, 32'd0);
    check("rst_strobes8", {29'b0, po8, fe8, pe8}, 32'd0);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_rx_data7", {25'b0, rx_data7}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // back-to-back 0x55, 0xA3
    frame8(8'h55, 1'b1, 1'b0, BIT_CLK, BIT_CLK);
    frame8(8'hA3, 1'b1, 1'b0, BIT_CLK, BIT_CLK);
    repeat (5) @(negedge clk);
    check8("b2b");

    // 3-clock glitch: START entered 3 clocks after the fall, rejected, idle within 10 clocks
    saw_busy8 = 1'b0;
    line8 = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch_busy_pre", {31'b0, busy8}, 32'd0);
    @(negedge clk);
    line8 = 1'b1;
    check("glitch_busy_start", {31'b0, busy8}, 32'd1);
    repeat (7) @(negedge clk);
    check("glitch_busy_done", {31'b0, busy8}, 32'd0);
    check("glitch_saw_busy", {31'b0, saw_busy8}, 32'd1);
    check8("glitch");

    // stop bit low, line held low 40 clocks, then 0x81
    frame8(8'h3C, 1'b0, 1'b0, BIT_CLK, BIT_CLK);
    repeat (30) @(negedge clk);
    check("break_busy", {31'b0, busy8}, 32'd1);
    check8("break");
    line8 = 1'b1;
    repeat (10) @(negedge clk);
    check("break_idle", {31'b0, busy8}, 32'd0);
    frame8(8'h81, 1'b1, 1'b0, BIT_CLK, BIT_CLK);
    repeat (5) @(negedge clk);
    check8("after_break");

    // reset during bit 4 of 0xFF
    line8 = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    line8 = 1'b1;
    repeat (4 * BIT_CLK + 5) @(negedge clk);
    rst_n = 1'b0;
    last8 = '0;
    last7 = '0;
    @(negedge clk);
    check("midrst_rx_data8", {24'b0, rx_data8}, 32'd0);
    check("midrst_busy8", {31'b0, busy8}, 32'd0);
    check("midrst_strobes8", {29'b0, po8, fe8, pe8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_idle", {31'b0, busy8}, 32'd0);
    frame8(8'h12, 1'b1, 1'b0, BIT_CLK, BIT_CLK);
    repeat (5) @(negedge clk);
    check8("after_rst");

    // 7-bit receiver
    frame7(7'h7F, 1'b0);
    repeat (5) @(negedge clk);
    check7("d7_7f");
    if (PAR_EN) begin
      frame7(7'h07, 1'b0);
      repeat (5) @(negedge clk);
      check7("d7_par_ok");
      frame7(7'h07, 1'b1);
      repeat (5) @(negedge clk);
      check7("d7_par_bad");
      frame8(8'hC6, 1'b1, 1'b1, BIT_CLK, BIT_CLK);
      repeat (5) @(negedge clk);
      check8("d8_par_bad");
    end

    // sampling margin: bit lengths of 9 and 11 clocks
    frame8(8'h5A, 1'b1, 1'b0, 9, 11);
    repeat (5) @(negedge clk);
    check8("margin_9_11");
    frame8(8'h5A, 1'b1, 1'b0, 11, 9);
    repeat (5) @(negedge clk);
    check8("margin_11_9");

    // random frames, random gaps (gap 0 = back-to-back)
    for (int i = 0; i < 10; i++) begin
      frame8(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 3) == 0), BIT_CLK, BIT_CLK);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check8("rand8");
    for (int i = 0; i < 6; i++) begin
      frame7(7'($urandom_range(0, 127)), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check7("rand7");
    check("fe7_count", n_fe7, e_fe7);

    check("exp_q8_empty", exp_q8.size(), 32'd0);
    check("exp_q7_empty", exp_q7.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
